// File: rtl/ser_resp.sv
// Serial register-access responder: command byte + data byte frames.
// Ports: clk, rst (async, active-high); ssel_n, sclk, sdi, sdo, sdo_oe
// serial pins; reg_addr, reg_wdata, reg_we, reg_rdata register-file side;
// par_err sticky parity error. Optional: SER_RESP_PARITY_EN adds an even
// parity bit after each data byte.
module ser_resp (
    input  logic       clk,
    input  logic       rst,
    input  logic       ssel_n,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       par_err
);

`ifdef SER_RESP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Index of the last data-phase bit (parity bit when enabled)
    localparam logic [3:0] DATA_LAST = PAR_EN ? 4'd8 : 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_DATA,
        S_DONE,
        S_IGNORE
    } state_t;

    state_t state, state_n;

    logic ssel_s1, ssel_s2, ssel_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic sdi_s1, sdi_s2;

    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [8:0] rsh, rsh_n;
    logic [3:0] addr_n;
    logic [7:0] wdata_n;
    logic       we_n, sdo_n, oe_n, perr_n;

    logic ssel_fall, ssel_rise, sclk_rise, sclk_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssel_s1 <= 1'b1;
            ssel_s2 <= 1'b1;
            ssel_d  <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            sdi_s1  <= 1'b0;
            sdi_s2  <= 1'b0;
        end else begin
            ssel_s1 <= ssel_n;
            ssel_s2 <= ssel_s1;
            ssel_d  <= ssel_s2;
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            sdi_s1  <= sdi;
            sdi_s2  <= sdi_s1;
        end
    end

    // sclk edges are qualified by the previous select level so an edge
    // arriving in the same clk as deselect still counts.
    assign ssel_fall = ssel_d & ~ssel_s2;
    assign ssel_rise = ~ssel_d & ssel_s2;
    assign sclk_rise = ~sclk_d & sclk_s2 & ~ssel_d;
    assign sclk_fall = sclk_d & ~sclk_s2 & ~ssel_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            shreg     <= 8'd0;
            rsh       <= 9'd0;
            reg_addr  <= 4'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            sdo       <= 1'b0;
            sdo_oe    <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            rsh       <= rsh_n;
            reg_addr  <= addr_n;
            reg_wdata <= wdata_n;
            reg_we    <= we_n;
            sdo       <= sdo_n;
            sdo_oe    <= oe_n;
            par_err   <= perr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        rsh_n   = rsh;
        addr_n  = reg_addr;
        wdata_n = reg_wdata;
        we_n    = 1'b0;
        sdo_n   = sdo;
        oe_n    = sdo_oe;
        perr_n  = par_err;

        unique case (state)
            S_IDLE: begin
                oe_n = 1'b0;
                if (ssel_fall) begin
                    state_n = S_CMD;
                    cnt_n   = 4'd0;
                    shreg_n = 8'd0;
                    perr_n  = 1'b0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    shreg_n = {shreg[6:0], sdi_s2};
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        addr_n = shreg_n[3:0];
                        cnt_n  = 4'd0;
                        if (shreg_n[6:4] != 3'b000)
                            state_n = S_IGNORE;
                        else if (shreg_n[7])
                            state_n = S_RD_DATA;
                        else
                            state_n = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (sclk_rise) begin
                    if (cnt < 4'd8)
                        shreg_n = {shreg[6:0], sdi_s2};
                    cnt_n = cnt + 4'd1;
                    if (cnt == DATA_LAST) begin
                        state_n = S_DONE;
                        if (!PAR_EN) begin
                            we_n    = 1'b1;
                            wdata_n = shreg_n;
                        end else if ((^shreg) == sdi_s2) begin
                            we_n    = 1'b1;
                            wdata_n = shreg;
                        end else begin
                            perr_n = 1'b1;
                        end
                    end
                end
            end
            S_RD_DATA: begin
                // First fall loads the byte; later falls shift it out.
                if (sclk_fall) begin
                    if (!sdo_oe) begin
                        rsh_n = {reg_rdata, PAR_EN & (^reg_rdata)};
                        sdo_n = reg_rdata[7];
                        oe_n  = 1'b1;
                    end else begin
                        rsh_n = {rsh[7:0], 1'b0};
                        sdo_n = rsh[7];
                    end
                end
                if (sclk_rise) begin
                    cnt_n = cnt + 4'd1;
                    if (cnt == DATA_LAST) begin
                        state_n = S_DONE;
                        oe_n    = 1'b0;
                        sdo_n   = 1'b0;
                    end
                end
            end
            S_DONE, S_IGNORE: begin
                oe_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
                oe_n    = 1'b0;
            end
        endcase

        // Deselect aborts from any state; a write completed this clk
        // keeps its strobe.
        if (ssel_rise) begin
            state_n = S_IDLE;
            oe_n    = 1'b0;
            sdo_n   = 1'b0;
            cnt_n   = 4'd0;
        end
    end

endmodule

// File: tb/tb_ser_resp.sv
// Self-checking bench for ser_resp: table-driven frames plus hand-written
// abort, reset and deselect corner sequences; write scoreboard queue.
module tb_ser_resp;

    localparam time HALF = 80ns;

    logic       clk = 1'b0;
    logic       rst;
    logic       ssel_n;
    logic       sclk;
    logic       sdi;
    logic       sdo;
    logic       sdo_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       par_err;

    int checks = 0;
    int errors = 0;
    bit oe_seen;

    logic [11:0] wq[$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rdata;
        int         kind;   // 0 ignored, 1 write, 2 read
    } vec_t;

    vec_t vt[6];

    ser_resp dut (
        .clk       (clk),
        .rst       (rst),
        .ssel_n    (ssel_n),
        .sclk      (sclk),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_oe    (sdo_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sdo_oe)
            oe_seen = 1'b1;
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst && reg_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we actual=%h_%h required=none",
                         reg_addr, reg_wdata);
            end else begin
                e = wq.pop_front();
                if ({reg_addr, reg_wdata} !== e) begin
                    errors++;
                    $display("FAIL write_sb actual=%h_%h required=%h_%h",
                             reg_addr, reg_wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data,
                              input int ndata, input bit desel_last,
                              output logic [7:0] rx);
        rx = 8'h00;
        oe_seen = 1'b0;
        ssel_n = 1'b0;
        #HALF;
        for (int i = 7; i >= 0; i--) begin
            sdi = cmd[i];
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        for (int i = 0; i < ndata; i++) begin
            sdi = data[7-i];
            #HALF;
            rx = {rx[6:0], sdo};
            if (desel_last && i == ndata - 1)
                ssel_n = 1'b1;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #HALF;
        ssel_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic post_checks(input string tag, input logic [3:0] addr,
                               input bit exp_oe);
        chk({tag, "_wq_empty"}, wq.size(), 0);
        chk({tag, "_addr"}, reg_addr, addr);
        chk({tag, "_oe_after"}, sdo_oe, 0);
        chk({tag, "_oe_seen"}, oe_seen, exp_oe);
    endtask

    initial begin
        logic [7:0] rx;

        vt[0] = '{cmd: 8'h05, data: 8'hA3, rdata: 8'h00, kind: 1};
        vt[1] = '{cmd: 8'h8C, data: 8'h00, rdata: 8'h5E, kind: 2};
        vt[2] = '{cmd: 8'h35, data: 8'h77, rdata: 8'h00, kind: 0};
        vt[3] = '{cmd: 8'h81, data: 8'h00, rdata: 8'hC3, kind: 2};
        vt[4] = '{cmd: 8'h0F, data: 8'h00, rdata: 8'hFF, kind: 1};
        vt[5] = '{cmd: 8'hC5, data: 8'h12, rdata: 8'hAA, kind: 0};

        rst = 1'b1;
        ssel_n = 1'b1;
        sclk = 1'b0;
        sdi = 1'b0;
        reg_rdata = 8'h00;
        #100ns;
        chk("reset_outs", {sdo, sdo_oe, reg_addr, reg_wdata, reg_we,
            par_err}, 0);
        rst = 1'b0;
        #100ns;

        for (int v = 0; v < 6; v++) begin
            reg_rdata = vt[v].rdata;
            if (vt[v].kind == 1)
                wq.push_back({vt[v].cmd[3:0], vt[v].data});
            send_frame(vt[v].cmd, vt[v].data, 8, 1'b0, rx);
            if (vt[v].kind == 2)
                chk($sformatf("rd_data_%0d", v), rx, vt[v].rdata);
            post_checks($sformatf("vec%0d", v), vt[v].cmd[3:0],
                        vt[v].kind == 2);
            chk($sformatf("par_err_%0d", v), par_err, 0);
        end

        // Partial write discarded, then a full write to the same address
        send_frame(8'h02, 8'h55, 5, 1'b0, rx);
        post_checks("partial", 4'h2, 1'b0);
        wq.push_back({4'h2, 8'hFF});
        send_frame(8'h02, 8'hFF, 8, 1'b0, rx);
        post_checks("after_partial", 4'h2, 1'b0);
        chk("after_partial_wdata", reg_wdata, 8'hFF);

        // Deselect coincident with the 8th data edge still writes
        wq.push_back({4'h7, 8'h5A});
        send_frame(8'h07, 8'h5A, 8, 1'b1, rx);
        post_checks("desel_last", 4'h7, 1'b0);

        // sclk activity while deselected is ignored
        for (int i = 0; i < 10; i++) begin
            sdi = i[0];
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        wq.push_back({4'h9, 8'h3C});
        send_frame(8'h09, 8'h3C, 8, 1'b0, rx);
        post_checks("idle_sclk", 4'h9, 1'b0);

        // Reset after 3 command bits
        ssel_n = 1'b0;
        #HALF;
        for (int i = 7; i >= 5; i--) begin
            sdi = i == 7;
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        rst = 1'b1;
        #30ns;
        chk("mid_rst_outs", {sdo, sdo_oe, reg_addr, reg_wdata, reg_we,
            par_err}, 0);
        ssel_n = 1'b1;
        #HALF;
        rst = 1'b0;
        #HALF;
        reg_rdata = 8'h96;
        send_frame(8'h81, 8'h00, 8, 1'b0, rx);
        chk("rst_read_data", rx, 8'h96);
        post_checks("rst_read", 4'h1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
